// File: rtl/spi_adc_rx_mc.sv
// SPI-slave ADC sample receiver: synchronises SCK/SDI, deserialises MSB-first words, tags channel, valid/ready out.
// Optional SDO echo of the last accepted word is built when SPI_SDO_ECHO_EN is defined.
module spi_adc_rx_mc #(
    parameter int DATA_W      = 16,
    parameter int NUM_CH      = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clk_100M,
    input  logic              ResetSwitch,
    input  logic              SCK,
    input  logic              SDI,
    output logic              SDO,
    output logic [DATA_W-1:0] Sample,
    output logic [CH_W-1:0]   SampleCh,
    output logic              SampleValid,
    input  logic              SampleReady,
    output logic              Overrun,
    input  logic              OverrunClr,
    output logic              FrameErr,
    output logic              SPI_LED
);

    localparam int BC_W   = $clog2(DATA_W);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_prev;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   rise;
    logic [DATA_W-1:0]      shift_reg;
    logic [DATA_W-1:0]      word;
    logic [BC_W-1:0]        bitcnt;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [CH_W-1:0]        chan;
    logic                   word_done;
    logic                   timeout;
    logic                   drain;
    logic                   load;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_prev;
    assign word      = {shift_reg[DATA_W-2:0], sdi_s};
    assign word_done = rise && (bitcnt == BC_W'(DATA_W - 1));
    assign timeout   = !rise && (idle_cnt == IDLE_W'(TIMEOUT_CYC)) && (bitcnt != '0);
    assign drain     = SampleValid & SampleReady;
    assign load      = word_done && (!SampleValid || drain);

    always_ff @(posedge Clk_100M or posedge ResetSwitch) begin
        if (ResetSwitch) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            sck_prev <= sck_s;
        end
    end

    always_ff @(posedge Clk_100M or posedge ResetSwitch) begin
        if (ResetSwitch) begin
            shift_reg <= '0;
            bitcnt    <= '0;
            idle_cnt  <= '0;
            chan      <= '0;
            FrameErr  <= 1'b0;
        end else begin
            FrameErr <= timeout;
            if (rise) begin
                shift_reg <= word;
                idle_cnt  <= '0;
                bitcnt    <= word_done ? '0 : bitcnt + 1'b1;
            end else begin
                if (idle_cnt != IDLE_W'(TIMEOUT_CYC))
                    idle_cnt <= idle_cnt + 1'b1;
                if (timeout)
                    bitcnt <= '0;
            end
            if (word_done)
                chan <= (chan == CH_W'(NUM_CH - 1)) ? '0 : chan + 1'b1;
            else if (timeout)
                chan <= '0;
        end
    end

    always_ff @(posedge Clk_100M or posedge ResetSwitch) begin
        if (ResetSwitch) begin
            Sample      <= '0;
            SampleCh    <= '0;
            SampleValid <= 1'b0;
            SPI_LED     <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            if (load) begin
                Sample      <= word;
                SampleCh    <= chan;
                SampleValid <= 1'b1;
                SPI_LED     <= ~SPI_LED;
            end else if (drain) begin
                SampleValid <= 1'b0;
            end
            // a dropped word outranks a clear arriving in the same cycle
            if (word_done && !load)
                Overrun <= 1'b1;
            else if (OverrunClr)
                Overrun <= 1'b0;
        end
    end

`ifdef SPI_SDO_ECHO_EN
    logic              fall;
    logic [DATA_W-1:0] echo_reg;

    assign fall = ~sck_s & sck_prev;
    assign SDO  = echo_reg[DATA_W-1];

    // The fall that ends a frame arrives with bitcnt back at 0; skipping it keeps the MSB for the next frame.
    always_ff @(posedge Clk_100M or posedge ResetSwitch) begin
        if (ResetSwitch)
            echo_reg <= '0;
        else if (load)
            echo_reg <= word;
        else if (fall && (bitcnt != '0))
            echo_reg <= {echo_reg[DATA_W-2:0], 1'b0};
    end
`else
    assign SDO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_adc_rx_mc.sv
// Randomised bench for spi_adc_rx_mc against a frame-level reference model.
module tb_spi_adc_rx_mc;

    localparam int DATA_W = 16;
    localparam int NUM_CH = 4;
    localparam int SYNC   = 2;
    localparam int TMO    = 1000;
    localparam int CH_W   = 2;
    localparam int HP     = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sck = 1'b0;
    logic              sdi = 1'b0;
    logic              ready = 1'b0;
    logic              ovr_clr = 1'b0;
    logic              sdo;
    logic [DATA_W-1:0] sample;
    logic [CH_W-1:0]   sample_ch;
    logic              valid;
    logic              ovr;
    logic              ferr;
    logic              led;

    spi_adc_rx_mc #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)
    ) dut (
        .Clk_100M(clk), .ResetSwitch(rst), .SCK(sck), .SDI(sdi), .SDO(sdo),
        .Sample(sample), .SampleCh(sample_ch), .SampleValid(valid), .SampleReady(ready),
        .Overrun(ovr), .OverrunClr(ovr_clr), .FrameErr(ferr), .SPI_LED(led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DATA_W+CH_W-1:0] exp_q[$];
    logic [DATA_W+CH_W-1:0] exp_item;
    int                     ch_model = 0;
    bit                     hold_full = 0;
    bit                     ovr_model = 0;
    bit                     led_model = 0;
    logic [DATA_W-1:0]      last_acc = '0;
    int                     n_xfer = 0;
    int                     valid_cycles = 0;
    int                     ferr_count = 0;
    int                     ferr_cycles = 0;
    int                     ferr_cyc = 0;
    bit                     ferr_prev = 0;
    int                     last_rise_cyc = 0;
    logic [DATA_W-1:0]      sdo_word = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) valid_cycles++;
            if (ferr) begin
                ferr_cycles++;
                if (!ferr_prev) begin
                    ferr_count++;
                    ferr_cyc = cyc;
                end
            end
            if (valid && ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("xfer_data", 32'(sample), 32'(exp_item[DATA_W+CH_W-1:CH_W]));
                    chk("xfer_ch", 32'(sample_ch), 32'(exp_item[CH_W-1:0]));
                end
            end
        end
        ferr_prev = ferr;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: every completed word takes the next channel; it is kept if the holding slot is free.
    task automatic model_word(input logic [DATA_W-1:0] data);
        int ch;
        ch = ch_model;
        ch_model = (ch_model + 1) % NUM_CH;
        if (!hold_full || ready) begin
            exp_q.push_back({data, CH_W'(ch)});
            led_model = ~led_model;
            last_acc  = data;
            hold_full = !ready;
        end else begin
            ovr_model = 1;
        end
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdi = data[DATA_W-1-i];
            wait_cyc(HP);
            sdo_word = {sdo_word[DATA_W-2:0], sdo};
            if (nbits == DATA_W && i == DATA_W - 1) model_word(data);
            sck = 1'b1;
            last_rise_cyc = cyc;
            wait_cyc(HP);
            sck = 1'b0;
        end
    endtask

    task automatic model_reset();
        ch_model = 0; hold_full = 0; ovr_model = 0; led_model = 0; last_acc = '0;
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sample"}, 32'(sample), 32'd0);
        chk({tag, "_ch"}, 32'(sample_ch), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_ovr"}, 32'(ovr), 32'd0);
        chk({tag, "_ferr"}, 32'(ferr), 32'd0);
        chk({tag, "_led"}, 32'(led), 32'd0);
        chk({tag, "_sdo"}, 32'(sdo), 32'd0);
    endtask

    initial begin
        int v0, x0, f0;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] exp_echo;

        // 1: reset state, single word with Ready=1
        wait_cyc(3);
        chk_all_zero("reset");
        rst = 1'b0;
        ready = 1'b1;
        wait_cyc(5);
        v0 = valid_cycles;
        send_bits(16'h01F4, DATA_W);
        wait_cyc(50);
        chk("t1_valid_pulse", 32'(valid_cycles - v0), 32'd1);
        chk("t1_led", 32'(led), 32'(led_model));
        chk("t1_ovr", 32'(ovr), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: backpressure, overrun, drain and clear
        ready = 1'b0;
        send_bits(16'h01F4, DATA_W);
        wait_cyc(2000);
        w = 16'($urandom);
        send_bits(w, DATA_W);
        wait_cyc(10);
        chk("t2_hold_sample", 32'(sample), 32'h01F4);
        chk("t2_hold_ch", 32'(sample_ch), 32'd1);
        chk("t2_hold_valid", 32'(valid), 32'd1);
        chk("t2_ovr_set", 32'(ovr), 32'(ovr_model));
        ready = 1'b1;
        hold_full = 0;
        wait_cyc(5);
        chk("t2_drained", 32'(valid), 32'd0);
        chk("t2_ovr_sticky", 32'(ovr), 32'd1);
        ovr_clr = 1'b1;
        wait_cyc(1);
        ovr_clr = 1'b0;
        ovr_model = 0;
        wait_cyc(2);
        chk("t2_ovr_clr", 32'(ovr), 32'(ovr_model));
        chk("t2_led", 32'(led), 32'(led_model));

        // 3: partial frame timeout
        x0 = n_xfer;
        f0 = ferr_count;
        send_bits(16'($urandom), 9);
        wait_cyc(2000);
        ch_model = 0;
        chk("t3_ferr_count", 32'(ferr_count - f0), 32'd1);
        chk("t3_ferr_width", 32'(ferr_cycles), 32'd1);
        chk("t3_ferr_delay", 32'((ferr_cyc - last_rise_cyc) >= TMO && (ferr_cyc - last_rise_cyc) <= TMO + SYNC + 4), 32'd1);
        chk("t3_no_valid", 32'(n_xfer - x0), 32'd0);
        send_bits(16'hA5A5, DATA_W);
        wait_cyc(10);
        chk("t3_recover", 32'(exp_q.size()), 32'd0);

        // 4: channel rotation, fixed then random words with random gaps
        for (int i = 1; i <= 5; i++) send_bits(16'(i), DATA_W);
        for (int i = 0; i < 8; i++) begin
            send_bits(16'($urandom), DATA_W);
            wait_cyc($urandom_range(0, 300));
        end
        wait_cyc(10);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_led", 32'(led), 32'(led_model));

        // 5: asynchronous reset mid-frame
        send_bits(16'hFFFF, 8);
        f0 = ferr_count;
        #3 rst = 1'b1;
        #1 chk_all_zero("midrst");
        model_reset();
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        send_bits(16'h8001, DATA_W);
        wait_cyc(1500);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_no_ferr", 32'(ferr_count - f0), 32'd0);

        // 6: SDO echo of the last accepted word
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 16'h01F4 : 16'($urandom);
            send_bits(w, DATA_W);
`ifdef SPI_SDO_ECHO_EN
            exp_echo = last_acc;
`else
            exp_echo = '0;
`endif
            send_bits((k == 0) ? 16'h0000 : 16'($urandom), DATA_W);
            chk("t6_echo", 32'(sdo_word), 32'(exp_echo));
        end
        wait_cyc(10);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
